// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the RV32I execute stage: decodes one R/I-type ALU
// instruction, drives a registered ALU, waits for its result and writes it back.
module alu_issue_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instr,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    output logic             alu_en,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_op,
    input  logic             alu_valid,
    input  logic [WIDTH-1:0] alu_result,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             illegal,
    output logic             timeout
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_MUL = 5'b00100;
    localparam logic [4:0] OP_DIV = 5'b01000;
    localparam logic [4:0] OP_REM = 5'b01001;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01100;
    localparam logic [4:0] OP_XOR = 5'b01101;
    localparam logic [4:0] OP_SLL = 5'b01110;
    localparam logic [4:0] OP_SRL = 5'b01111;
    localparam logic [4:0] OP_SRA = 5'b10000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_ERR
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [4:0]       rd_reg, rd_next;
    logic             alu_en_reg, alu_en_next;
    logic [WIDTH-1:0] alu_a_reg, alu_a_next;
    logic [WIDTH-1:0] alu_b_reg, alu_b_next;
    logic [4:0]       alu_op_reg, alu_op_next;
    logic             wb_valid_reg, wb_valid_next;
    logic [4:0]       wb_rd_reg, wb_rd_next;
    logic [WIDTH-1:0] wb_data_reg, wb_data_next;
    logic             illegal_reg, illegal_next;
    logic             timeout_reg, timeout_next;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] shamt_ext;
    logic             dec_legal;
    logic [4:0]       dec_op;
    logic [WIDTH-1:0] dec_b;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_sext  = {{(WIDTH-12){instr[31]}}, instr[31:20]};
    assign shamt_ext = {{(WIDTH-5){1'b0}}, instr[24:20]};

    assign rs1_addr    = instr[19:15];
    assign rs2_addr    = instr[24:20];
    assign instr_ready = (state_reg == S_IDLE);

    // Decode is purely combinational on the presented word; only used in the accept cycle.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 5'b00000;
        dec_b     = rs2_data;
        case (opcode)
            OPC_R: begin
                case (funct7)
                    F7_BASE: begin
                        dec_legal = 1'b1;
                        case (funct3)
                            3'b000:  dec_op = OP_ADD;
                            3'b111:  dec_op = OP_AND;
                            3'b110:  dec_op = OP_OR;
                            3'b100:  dec_op = OP_XOR;
                            3'b001:  dec_op = OP_SLL;
                            3'b101:  dec_op = OP_SRL;
                            default: dec_legal = 1'b0;
                        endcase
                    end
                    F7_ALT: begin
                        dec_legal = 1'b1;
                        case (funct3)
                            3'b000:  dec_op = OP_SUB;
                            3'b101:  dec_op = OP_SRA;
                            default: dec_legal = 1'b0;
                        endcase
                    end
                    F7_MULDIV: begin
                        dec_legal = 1'b1;
                        case (funct3)
                            3'b000:  dec_op = OP_MUL;
                            3'b100:  dec_op = OP_DIV;
                            3'b110:  dec_op = OP_REM;
                            default: dec_legal = 1'b0;
                        endcase
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_I: begin
                dec_b = imm_sext;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD; end
                    3'b111: begin dec_legal = 1'b1; dec_op = OP_AND; end
                    3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;  end
                    3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR; end
                    3'b001: begin
                        dec_b = shamt_ext;
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SLL;
                        end
                    end
                    3'b101: begin
                        dec_b = shamt_ext;
                        if (funct7 == F7_BASE) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_legal = 1'b1;
                            dec_op    = OP_SRA;
                        end
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Pulsed outputs are computed alongside the transition so they are high
    // for exactly the cycle the FSM spends in the matching state.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        rd_next       = rd_reg;
        alu_en_next   = 1'b0;
        alu_a_next    = alu_a_reg;
        alu_b_next    = alu_b_reg;
        alu_op_next   = alu_op_reg;
        wb_valid_next = 1'b0;
        wb_rd_next    = wb_rd_reg;
        wb_data_next  = wb_data_reg;
        illegal_next  = 1'b0;
        timeout_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (instr_valid) begin
                    if (dec_legal) begin
                        state_next  = S_ISSUE;
                        alu_en_next = 1'b1;
                        alu_a_next  = rs1_data;
                        alu_b_next  = dec_b;
                        alu_op_next = dec_op;
                        rd_next     = instr[11:7];
                    end else begin
                        state_next   = S_ERR;
                        illegal_next = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
                count_next = '0;
            end
            S_WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (alu_valid) begin
                    state_next    = S_WB;
                    wb_data_next  = alu_result;
                    wb_rd_next    = rd_reg;
                    wb_valid_next = (rd_reg != 5'd0);
                end else if (count_reg == CNT_LAST) begin
                    state_next   = S_IDLE;
                    timeout_next = 1'b1;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            S_WB: begin
                state_next = S_IDLE;
            end
            S_ERR: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            rd_reg       <= 5'd0;
            alu_en_reg   <= 1'b0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= 5'd0;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= 5'd0;
            wb_data_reg  <= '0;
            illegal_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            rd_reg       <= rd_next;
            alu_en_reg   <= alu_en_next;
            alu_a_reg    <= alu_a_next;
            alu_b_reg    <= alu_b_next;
            alu_op_reg   <= alu_op_next;
            wb_valid_reg <= wb_valid_next;
            wb_rd_reg    <= wb_rd_next;
            wb_data_reg  <= wb_data_next;
            illegal_reg  <= illegal_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign alu_en   = alu_en_reg;
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign alu_op   = alu_op_reg;
    assign wb_valid = wb_valid_reg;
    assign wb_rd    = wb_rd_reg;
    assign wb_data  = wb_data_reg;
    assign illegal  = illegal_reg;
    assign timeout  = timeout_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a one-cycle registered ALU model;
// all inputs are driven and all outputs sampled on the falling edge.
module tb_alu_issue_ctrl;

    localparam int WIDTH      = 32;
    localparam int TB_TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic             alu_en;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_op;
    logic             alu_valid;
    logic [WIDTH-1:0] alu_result;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             illegal;
    logic             timeout;

    logic alu_on;
    logic alu_force;
    logic alu_valid_m;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_valid(alu_valid), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .illegal(illegal), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: valid follows en by one cycle; result tracks operands every cycle.
    assign alu_valid = alu_valid_m | alu_force;
    always @(posedge clk) begin
        if (rst) alu_valid_m <= 1'b0;
        else     alu_valid_m <= alu_en & alu_on;
        case (alu_op)
            5'b00001: alu_result <= alu_a + alu_b;
            5'b00011: alu_result <= alu_a - alu_b;
            5'b10000: alu_result <= 32'($signed(alu_a) >>> alu_b[4:0]);
            default:  alu_result <= alu_a ^ alu_b;
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Drives one instruction and samples at fixed offsets after the accept edge.
    task automatic run_op(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                          output logic en1, output logic [4:0] op1,
                          output logic [31:0] a1, output logic [31:0] b1,
                          output logic wb2, output logic wb3, output logic [4:0] rd3,
                          output logic [31:0] data3, output logic rdy3, output logic rdy4);
        @(negedge clk);
        instr = ins; rs1_data = d1; rs2_data = d2; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        en1 = alu_en; op1 = alu_op; a1 = alu_a; b1 = alu_b;
        @(negedge clk);
        wb2 = wb_valid;
        @(negedge clk);
        wb3 = wb_valid; rd3 = wb_rd; data3 = wb_data; rdy3 = instr_ready;
        @(negedge clk);
        rdy4 = instr_ready;
        $display("txn instr=%h op=%b a=%h b=%h wb=%b rd=%0d data=%h", ins, op1, a1, b1, wb3, rd3, data3);
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; rs1_data = '0; rs2_data = '0;
        alu_on = 1'b1; alu_force = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", instr_ready); end
        n_cmp++; if ({alu_en, wb_valid, illegal, timeout} !== 4'b0000) begin n_err++; $display("FAIL reset_pulses got %b want 0000", {alu_en, wb_valid, illegal, timeout}); end
        n_cmp++; if ({alu_a, alu_b, alu_op} !== 69'd0) begin n_err++; $display("FAIL reset_alu_regs got a=%h b=%h op=%b want 0", alu_a, alu_b, alu_op); end
        n_cmp++; if ({wb_rd, wb_data} !== 37'd0) begin n_err++; $display("FAIL reset_wb_regs got rd=%0d data=%h want 0", wb_rd, wb_data); end
        rst = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_add();
        @(negedge clk);
        alu_on = 1'b1;
        instr = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
        rs1_data = 32'd5; rs2_data = 32'd7; instr_valid = 1'b1;
        #1;
        n_cmp++; if ({rs1_addr, rs2_addr} !== {5'd1, 5'd2}) begin n_err++; $display("FAIL add_rs_addr got %0d,%0d want 1,2", rs1_addr, rs2_addr); end
        @(negedge clk);
        instr_valid = 1'b0;
        n_cmp++; if (alu_en !== 1'b1) begin n_err++; $display("FAIL add_en got %b want 1", alu_en); end
        n_cmp++; if (alu_op !== 5'b00001) begin n_err++; $display("FAIL add_op got %b want 00001", alu_op); end
        n_cmp++; if ({alu_a, alu_b} !== {32'd5, 32'd7}) begin n_err++; $display("FAIL add_operands got a=%h b=%h want 5,7", alu_a, alu_b); end
        n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL add_busy got %b want 0", instr_ready); end
        @(negedge clk);
        n_cmp++; if ({alu_en, wb_valid} !== 2'b00) begin n_err++; $display("FAIL add_wait got en/wb=%b want 00", {alu_en, wb_valid}); end
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL add_wb_valid got %b want 1", wb_valid); end
        n_cmp++; if ({wb_rd, wb_data} !== {5'd3, 32'd12}) begin n_err++; $display("FAIL add_wb got rd=%0d data=%h want 3,0000000c", wb_rd, wb_data); end
        @(negedge clk);
        n_cmp++; if ({wb_valid, instr_ready} !== 2'b01) begin n_err++; $display("FAIL add_done got wb/ready=%b want 01", {wb_valid, instr_ready}); end
        $display("txn add x3,x1,x2 data=%h", wb_data);
    endtask

    task automatic test_imm();
        logic en1, wb2, wb3, rdy3, rdy4;
        logic [4:0] op1, rd3;
        logic [31:0] a1, b1, data3;
        alu_on = 1'b1;
        run_op(enc_i(12'hFFF, 5'd1, 3'b000, 5'd4), 32'd0, 32'h55, en1, op1, a1, b1, wb2, wb3, rd3, data3, rdy3, rdy4);
        n_cmp++; if ({op1, b1} !== {5'b00001, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL addi_dec got op=%b b=%h want 00001 ffffffff", op1, b1); end
        n_cmp++; if ({wb3, rd3, data3} !== {1'b1, 5'd4, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL addi_wb got v=%b rd=%0d data=%h want 1 4 ffffffff", wb3, rd3, data3); end
        run_op(enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd5), 32'h8000_0000, 32'h55, en1, op1, a1, b1, wb2, wb3, rd3, data3, rdy3, rdy4);
        n_cmp++; if ({op1, b1} !== {5'b10000, 32'd3}) begin n_err++; $display("FAIL srai_dec got op=%b b=%h want 10000 3", op1, b1); end
        n_cmp++; if ({wb3, rd3, data3} !== {1'b1, 5'd5, 32'hF000_0000}) begin n_err++; $display("FAIL srai_wb got v=%b rd=%0d data=%h want 1 5 f0000000", wb3, rd3, data3); end
    endtask

    task automatic test_decode_table();
        logic [31:0] tv_instr [15];
        logic [4:0]  tv_op    [15];
        logic [31:0] tv_b     [15];
        logic en1, wb2, wb3, rdy3, rdy4;
        logic [4:0] op1, rd3;
        logic [31:0] a1, b1, data3;
        tv_instr[0]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd9); tv_op[0]  = 5'b01010; tv_b[0]  = 32'hFF;
        tv_instr[1]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd9); tv_op[1]  = 5'b01100; tv_b[1]  = 32'hFF;
        tv_instr[2]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd9); tv_op[2]  = 5'b01101; tv_b[2]  = 32'hFF;
        tv_instr[3]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd9); tv_op[3]  = 5'b01110; tv_b[3]  = 32'hFF;
        tv_instr[4]  = enc_r(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd9); tv_op[4]  = 5'b01111; tv_b[4]  = 32'hFF;
        tv_instr[5]  = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd9); tv_op[5]  = 5'b00011; tv_b[5]  = 32'hFF;
        tv_instr[6]  = enc_r(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd9); tv_op[6]  = 5'b10000; tv_b[6]  = 32'hFF;
        tv_instr[7]  = enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd9); tv_op[7]  = 5'b00100; tv_b[7]  = 32'hFF;
        tv_instr[8]  = enc_r(7'b0000001, 5'd2, 5'd1, 3'b100, 5'd9); tv_op[8]  = 5'b01000; tv_b[8]  = 32'hFF;
        tv_instr[9]  = enc_r(7'b0000001, 5'd2, 5'd1, 3'b110, 5'd9); tv_op[9]  = 5'b01001; tv_b[9]  = 32'hFF;
        tv_instr[10] = enc_i(12'h80F, 5'd1, 3'b111, 5'd9);           tv_op[10] = 5'b01010; tv_b[10] = 32'hFFFF_F80F;
        tv_instr[11] = enc_i(12'h07F, 5'd1, 3'b110, 5'd9);           tv_op[11] = 5'b01100; tv_b[11] = 32'h7F;
        tv_instr[12] = enc_i(12'hFFF, 5'd1, 3'b100, 5'd9);           tv_op[12] = 5'b01101; tv_b[12] = 32'hFFFF_FFFF;
        tv_instr[13] = enc_i({7'b0000000, 5'd5}, 5'd1, 3'b001, 5'd9);  tv_op[13] = 5'b01110; tv_b[13] = 32'd5;
        tv_instr[14] = enc_i({7'b0000000, 5'd31}, 5'd1, 3'b101, 5'd9); tv_op[14] = 5'b01111; tv_b[14] = 32'd31;
        alu_on = 1'b1;
        for (int i = 0; i < 15; i++) begin
            run_op(tv_instr[i], 32'h1234, 32'hFF, en1, op1, a1, b1, wb2, wb3, rd3, data3, rdy3, rdy4);
            n_cmp++; if ({en1, op1} !== {1'b1, tv_op[i]}) begin n_err++; $display("FAIL dec%0d_op got en=%b op=%b want 1 %b", i, en1, op1, tv_op[i]); end
            n_cmp++; if ({a1, b1} !== {32'h1234, tv_b[i]}) begin n_err++; $display("FAIL dec%0d_ab got a=%h b=%h want 00001234 %h", i, a1, b1, tv_b[i]); end
            n_cmp++; if ({wb2, wb3, rd3, rdy4} !== {1'b0, 1'b1, 5'd9, 1'b1}) begin n_err++; $display("FAIL dec%0d_wb got wb2=%b wb3=%b rd=%0d rdy=%b want 0 1 9 1", i, wb2, wb3, rd3, rdy4); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [6];
        bad[0] = enc_r(7'b0000000, 5'd3, 5'd2, 3'b010, 5'd1);
        bad[1] = enc_i(12'h005, 5'd2, 3'b011, 5'd1);
        bad[2] = {12'h000, 5'd2, 3'b010, 5'd1, 7'b0000011};
        bad[3] = enc_r(7'b0000001, 5'd3, 5'd2, 3'b001, 5'd1);
        bad[4] = enc_i({7'b0100000, 5'd3}, 5'd2, 3'b001, 5'd1);
        bad[5] = enc_r(7'b0000010, 5'd3, 5'd2, 3'b000, 5'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instr = bad[i]; instr_valid = 1'b1;
            @(negedge clk);
            instr_valid = 1'b0;
            n_cmp++; if ({illegal, alu_en, instr_ready} !== 3'b100) begin n_err++; $display("FAIL ill%0d_pulse got ill/en/rdy=%b want 100", i, {illegal, alu_en, instr_ready}); end
            @(negedge clk);
            n_cmp++; if ({illegal, wb_valid, alu_en, instr_ready} !== 4'b0001) begin n_err++; $display("FAIL ill%0d_after got ill/wb/en/rdy=%b want 0001", i, {illegal, wb_valid, alu_en, instr_ready}); end
            $display("txn illegal instr=%h", bad[i]);
        end
    endtask

    task automatic test_rd_zero();
        logic en1, wb2, wb3, rdy3, rdy4;
        logic [4:0] op1, rd3;
        logic [31:0] a1, b1, data3;
        alu_on = 1'b1;
        run_op(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0), 32'd5, 32'd7, en1, op1, a1, b1, wb2, wb3, rd3, data3, rdy3, rdy4);
        n_cmp++; if (en1 !== 1'b1) begin n_err++; $display("FAIL rd0_en got %b want 1", en1); end
        n_cmp++; if ({wb2, wb3} !== 2'b00) begin n_err++; $display("FAIL rd0_wb got %b want 00", {wb2, wb3}); end
        n_cmp++; if ({rdy3, rdy4} !== 2'b01) begin n_err++; $display("FAIL rd0_wb_state got rdy3/rdy4=%b want 01", {rdy3, rdy4}); end
    endtask

    task automatic test_timeout();
        int t_first;
        int t_count;
        logic wb_any;
        t_first = -1; t_count = 0; wb_any = 1'b0;
        alu_on = 1'b0;
        @(negedge clk);
        instr = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3); rs1_data = 32'd1; rs2_data = 32'd1;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        n_cmp++; if (alu_en !== 1'b1) begin n_err++; $display("FAIL to_en got %b want 1", alu_en); end
        for (int j = 2; j <= TB_TIMEOUT + 6; j++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                if (t_first < 0) t_first = j;
                t_count++;
            end
            if (wb_valid !== 1'b0) wb_any = 1'b1;
        end
        n_cmp++; if (t_first !== TB_TIMEOUT + 2) begin n_err++; $display("FAIL to_when got sample %0d want %0d", t_first, TB_TIMEOUT + 2); end
        n_cmp++; if (t_count !== 1) begin n_err++; $display("FAIL to_width got %0d want 1", t_count); end
        n_cmp++; if (wb_any !== 1'b0) begin n_err++; $display("FAIL to_no_wb got %b want 0", wb_any); end
        alu_force = 1'b1;
        @(negedge clk);
        alu_force = 1'b0;
        n_cmp++; if ({wb_valid, instr_ready} !== 2'b01) begin n_err++; $display("FAIL idle_valid_ignored got wb/rdy=%b want 01", {wb_valid, instr_ready}); end
        $display("txn timeout after %0d samples", t_first);
    endtask

    task automatic test_valid_at_limit();
        alu_on = 1'b0;
        @(negedge clk);
        instr = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3); rs1_data = 32'd5; rs2_data = 32'd7;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int j = 2; j <= TB_TIMEOUT + 1; j++) begin
            @(negedge clk);
        end
        alu_force = 1'b1;
        @(negedge clk);
        alu_force = 1'b0;
        n_cmp++; if ({wb_valid, timeout} !== 2'b10) begin n_err++; $display("FAIL limit_wins got wb/to=%b want 10", {wb_valid, timeout}); end
        n_cmp++; if ({wb_rd, wb_data} !== {5'd3, 32'd12}) begin n_err++; $display("FAIL limit_data got rd=%0d data=%h want 3 0000000c", wb_rd, wb_data); end
        @(negedge clk);
        $display("txn valid on last wait cycle data=%h", wb_data);
    endtask

    task automatic test_reset_in_wait();
        logic flag_any;
        flag_any = 1'b0;
        alu_on = 1'b0;
        @(negedge clk);
        instr = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3); rs1_data = 32'd9; rs2_data = 32'd4;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({alu_en, wb_valid, illegal, timeout, instr_ready} !== 5'b00001) begin n_err++; $display("FAIL rstw_ctrl got %b want 00001", {alu_en, wb_valid, illegal, timeout, instr_ready}); end
        n_cmp++; if ({alu_a, alu_b, alu_op, wb_rd, wb_data} !== 106'd0) begin n_err++; $display("FAIL rstw_regs got a=%h b=%h op=%b rd=%0d data=%h want 0", alu_a, alu_b, alu_op, wb_rd, wb_data); end
        for (int j = 0; j < TB_TIMEOUT + 4; j++) begin
            @(negedge clk);
            if ({timeout, wb_valid, alu_en} !== 3'b000) flag_any = 1'b1;
        end
        n_cmp++; if (flag_any !== 1'b0) begin n_err++; $display("FAIL rstw_quiet got %b want 0", flag_any); end
        $display("txn reset during wait");
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [3];
        logic [31:0] d1s [3];
        logic [31:0] d2s [3];
        int acc_cyc [3];
        logic [4:0]  got_rd [3];
        logic [31:0] got_data [3];
        int idx;
        int nwb;
        ops[0] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd6); d1s[0] = 32'd1;    d2s[0] = 32'd2;
        ops[1] = enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd7); d1s[1] = 32'd10;   d2s[1] = 32'd3;
        ops[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd8); d1s[2] = 32'hF0;   d2s[2] = 32'h0F;
        idx = 0; nwb = 0;
        for (int k = 0; k < 3; k++) begin acc_cyc[k] = -1; got_rd[k] = 5'd0; got_data[k] = '0; end
        alu_on = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (nwb < 3) begin got_rd[nwb] = wb_rd; got_data[nwb] = wb_data; end
                nwb++;
            end
            if (instr_ready === 1'b1) begin
                if (idx < 3) begin
                    instr = ops[idx]; rs1_data = d1s[idx]; rs2_data = d2s[idx];
                    instr_valid = 1'b1; acc_cyc[idx] = c; idx++;
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        instr_valid = 1'b0;
        n_cmp++; if ({acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]} !== {32'sd4, 32'sd4}) begin n_err++; $display("FAIL b2b_spacing got %0d,%0d want 4,4", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); end
        n_cmp++; if (nwb !== 3) begin n_err++; $display("FAIL b2b_count got %0d want 3", nwb); end
        n_cmp++; if ({got_rd[0], got_rd[1], got_rd[2]} !== {5'd6, 5'd7, 5'd8}) begin n_err++; $display("FAIL b2b_order got %0d,%0d,%0d want 6,7,8", got_rd[0], got_rd[1], got_rd[2]); end
        n_cmp++; if ({got_data[0], got_data[1], got_data[2]} !== {32'd3, 32'd7, 32'hFF}) begin n_err++; $display("FAIL b2b_data got %h,%h,%h want 3,7,ff", got_data[0], got_data[1], got_data[2]); end
        for (int k = 0; k < 3; k++) $display("txn b2b rd=%0d data=%h", got_rd[k], got_data[k]);
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_decode_table();
        test_illegal();
        test_rd_zero();
        test_timeout();
        test_valid_at_limit();
        test_reset_in_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
